// File: rtl/rgb_to_raw_pkg.sv
// Shared transfer-mode/depth encodings and the component depth-widening helper
// for the RGB-to-RAW converter.
package rgb_to_raw_pkg;

  typedef enum logic [1:0] {
    MODE_ORIGINAL     = 2'd0,
    MODE_YUV422       = 2'd1,
    MODE_RGGB         = 2'd2,
    MODE_ORIGINAL_ALT = 2'd3
  } xferMode_e;

  typedef enum logic [1:0] {
    BITS_8      = 2'd0,
    BITS_10     = 2'd1,
    BITS_12     = 2'd2,
    BITS_12_ALT = 2'd3
  } rawDepth_e;

  localparam int DEPTH_BASE = 8;

  function automatic int depthBits(input rawDepth_e code, input int maxBits);
    int n;
    case (code)
      BITS_8:  n = 8;
      BITS_10: n = 10;
      default: n = 12;
    endcase
    if (n > maxBits) n = maxBits;
    return n;
  endfunction

  // Left-justify an 8-bit component inside an N-bit sample (N clamped to the slot width).
  function automatic logic [15:0] depthShift(input logic [7:0] value, input rawDepth_e code,
                                             input int maxBits);
    int n;
    n = depthBits(code, maxBits);
    return {8'd0, value} << (n - DEPTH_BASE);
  endfunction

endpackage

// File: rtl/rgb_to_raw_pix.sv
// Per-pixel component selection and depth widening; purely combinational,
// registered by the top.
module rgb_to_raw_pix
  import rgb_to_raw_pkg::*;
#(
  parameter int C_OUT_MAX_CPNTS_PER_PIXEL = 3,
  parameter int C_OUT_MAX_BITS_PER_CPNT   = 8
) (
  input  logic [7:0]  r_i,
  input  logic [7:0]  g_i,
  input  logic [7:0]  b_i,
  input  logic        pixOdd_i,
  input  logic        lineOdd_i,
  input  xferMode_e   mode_i,
  input  rawDepth_e   depth_i,
  output logic [C_OUT_MAX_CPNTS_PER_PIXEL*C_OUT_MAX_BITS_PER_CPNT-1:0] slot_o
);

  localparam int BITS = C_OUT_MAX_BITS_PER_CPNT;

  function automatic logic [7:0] pickCpnt(input int idx, input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b, input logic pixOdd,
                                          input logic lineOdd, input xferMode_e mode);
    logic [7:0] s;
    s = 8'd0;
    case (mode)
      MODE_YUV422: begin
        if (idx == 0) s = r;
        else if (idx == 1) s = pixOdd ? b : g;
      end
      // Bayer RGGB: even lines alternate R/G, odd lines alternate G/B
      MODE_RGGB: begin
        if (idx == 0) s = lineOdd ? (pixOdd ? b : g) : (pixOdd ? g : r);
      end
      default: begin
        if (idx == 0) s = r;
        else if (idx == 1) s = g;
        else if (idx == 2) s = b;
      end
    endcase
    return s;
  endfunction

  for (genvar c = 0; c < C_OUT_MAX_CPNTS_PER_PIXEL; c++) begin : g_cpnt
    assign slot_o[c*BITS +: BITS] =
      BITS'(depthShift(pickCpnt(c, r_i, g_i, b_i, pixOdd_i, lineOdd_i, mode_i), depth_i, BITS));
  end

endmodule

// File: rtl/rgb_to_raw_cvt.sv
// Multi-pixel RGB/YUV to packed component bus converter: frame config capture,
// line/beat parity tracking and a fixed two-stage data/sync pipeline.
module rgb_to_raw_cvt
  import rgb_to_raw_pkg::*;
#(
  parameter int C_IN_BPP                  = 8,
  parameter int C_IN_PORT_NUM             = 4,
  parameter int C_OUT_MAX_CPNTS_PER_PIXEL = 3,
  parameter int C_OUT_MAX_BITS_PER_CPNT   = 8
) (
  input  logic                                  VID_CLK,
  input  logic                                  VID_RSTN,
  input  logic                                  S_VS,
  input  logic                                  S_HS,
  input  logic                                  S_DE,
  input  logic [C_IN_BPP*C_IN_PORT_NUM-1:0]     S_R_Y,
  input  logic [C_IN_BPP*C_IN_PORT_NUM-1:0]     S_G_U,
  input  logic [C_IN_BPP*C_IN_PORT_NUM-1:0]     S_B_V,
  input  logic [1:0]                            TRANSFER_MODE,
  input  logic [1:0]                            RAW_BIT_NUM,
  output logic                                  M_VS,
  output logic                                  M_HS,
  output logic                                  M_DE,
  output logic [C_IN_PORT_NUM*C_OUT_MAX_CPNTS_PER_PIXEL*C_OUT_MAX_BITS_PER_CPNT-1:0] M_VID_DATA
);

  localparam int IN_W     = C_IN_BPP * C_IN_PORT_NUM;
  localparam int SLOT_W   = C_OUT_MAX_CPNTS_PER_PIXEL * C_OUT_MAX_BITS_PER_CPNT;
  localparam int OUT_W    = C_IN_PORT_NUM * SLOT_W;
  localparam logic PORT_ODD = (C_IN_PORT_NUM % 2) == 1;

  logic            vs1_q, hs1_q, de1_q;
  logic [IN_W-1:0] r1_q, g1_q, b1_q;
  logic            lineOdd1_q, beatOdd1_q;
  logic            lineParity_q, lineParity_d;
  logic            beatParity_q, beatParity_d;
  logic            frameStarted_q;
  xferMode_e       mode_q;
  rawDepth_e       depth_q;
  logic            vs2_q, hs2_q, de2_q;
  logic [OUT_W-1:0] data2_q;
  logic [OUT_W-1:0] pixData;

  logic vsRise, deRise, deFall;
  logic lineCur, beatCur;

  // Stage-1 registers double as the previous-cycle samples for edge detection.
  always_comb begin
    vsRise       = S_VS & ~vs1_q;
    deRise       = S_DE & ~de1_q;
    deFall       = ~S_DE & de1_q;
    lineCur      = vsRise ? 1'b0 : lineParity_q;
    lineParity_d = vsRise ? 1'b0 : (deFall ? ~lineParity_q : lineParity_q);
    beatCur      = deRise ? 1'b0 : beatParity_q;
    beatParity_d = S_DE ? ~beatCur : beatParity_q;
  end

  always_ff @(posedge VID_CLK or negedge VID_RSTN) begin
    if (!VID_RSTN) begin
      frameStarted_q <= 1'b0;
      mode_q         <= MODE_ORIGINAL;
      depth_q        <= BITS_8;
    end else begin
      if (vsRise) frameStarted_q <= 1'b1;
      if (vsRise || !frameStarted_q) begin
        mode_q  <= xferMode_e'(TRANSFER_MODE);
        depth_q <= rawDepth_e'(RAW_BIT_NUM);
      end
    end
  end

  always_ff @(posedge VID_CLK or negedge VID_RSTN) begin
    if (!VID_RSTN) begin
      vs1_q        <= 1'b0;
      hs1_q        <= 1'b0;
      de1_q        <= 1'b0;
      r1_q         <= '0;
      g1_q         <= '0;
      b1_q         <= '0;
      lineOdd1_q   <= 1'b0;
      beatOdd1_q   <= 1'b0;
      lineParity_q <= 1'b0;
      beatParity_q <= 1'b0;
    end else begin
      vs1_q        <= S_VS;
      hs1_q        <= S_HS;
      de1_q        <= S_DE;
      r1_q         <= S_R_Y;
      g1_q         <= S_G_U;
      b1_q         <= S_B_V;
      lineOdd1_q   <= lineCur;
      beatOdd1_q   <= beatCur;
      lineParity_q <= lineParity_d;
      beatParity_q <= beatParity_d;
    end
  end

  for (genvar p = 0; p < C_IN_PORT_NUM; p++) begin : g_pix
    localparam logic P_ODD = (p % 2) == 1;
    rgb_to_raw_pix #(
      .C_OUT_MAX_CPNTS_PER_PIXEL (C_OUT_MAX_CPNTS_PER_PIXEL),
      .C_OUT_MAX_BITS_PER_CPNT   (C_OUT_MAX_BITS_PER_CPNT)
    ) u_pix (
      .r_i       (r1_q[p*C_IN_BPP +: C_IN_BPP]),
      .g_i       (g1_q[p*C_IN_BPP +: C_IN_BPP]),
      .b_i       (b1_q[p*C_IN_BPP +: C_IN_BPP]),
      .pixOdd_i  ((beatOdd1_q & PORT_ODD) ^ P_ODD),
      .lineOdd_i (lineOdd1_q),
      .mode_i    (mode_q),
      .depth_i   (depth_q),
      .slot_o    (pixData[p*SLOT_W +: SLOT_W])
    );
  end

  always_ff @(posedge VID_CLK or negedge VID_RSTN) begin
    if (!VID_RSTN) begin
      vs2_q   <= 1'b0;
      hs2_q   <= 1'b0;
      de2_q   <= 1'b0;
      data2_q <= '0;
    end else begin
      vs2_q   <= vs1_q;
      hs2_q   <= hs1_q;
      de2_q   <= de1_q;
      data2_q <= de1_q ? pixData : '0;
    end
  end

  assign M_VS       = vs2_q;
  assign M_HS       = hs2_q;
  assign M_DE       = de2_q;
  assign M_VID_DATA = data2_q;

endmodule

// File: tb/tb_rgb_to_raw_cvt.sv
// Directed self-checking bench for rgb_to_raw_cvt with 2 component slots of 12 bits
// and fixed pixel data on all three colour buses.
module tb_rgb_to_raw_cvt;

  localparam int PORTS  = 4;
  localparam int CPNTS  = 2;
  localparam int BITS   = 12;
  localparam int DATA_W = PORTS * CPNTS * BITS;

  logic              VID_CLK = 1'b0;
  logic              VID_RSTN;
  logic              S_VS, S_HS, S_DE;
  logic [31:0]       S_R_Y, S_G_U, S_B_V;
  logic [1:0]        TRANSFER_MODE, RAW_BIT_NUM;
  logic              M_VS, M_HS, M_DE;
  logic [DATA_W-1:0] M_VID_DATA;

  int checks = 0;
  int errors = 0;

  rgb_to_raw_cvt #(
    .C_IN_BPP                  (8),
    .C_IN_PORT_NUM             (PORTS),
    .C_OUT_MAX_CPNTS_PER_PIXEL (CPNTS),
    .C_OUT_MAX_BITS_PER_CPNT   (BITS)
  ) dut (
    .VID_CLK       (VID_CLK),
    .VID_RSTN      (VID_RSTN),
    .S_VS          (S_VS),
    .S_HS          (S_HS),
    .S_DE          (S_DE),
    .S_R_Y         (S_R_Y),
    .S_G_U         (S_G_U),
    .S_B_V         (S_B_V),
    .TRANSFER_MODE (TRANSFER_MODE),
    .RAW_BIT_NUM   (RAW_BIT_NUM),
    .M_VS          (M_VS),
    .M_HS          (M_HS),
    .M_DE          (M_DE),
    .M_VID_DATA    (M_VID_DATA)
  );

  always #5 VID_CLK = ~VID_CLK;

  // Pixel p occupies 24 bits: c1 in the upper 12, c0 in the lower 12.
  function automatic logic [DATA_W-1:0] mk(input logic [11:0] p0c0, input logic [11:0] p0c1,
                                           input logic [11:0] p1c0, input logic [11:0] p1c1,
                                           input logic [11:0] p2c0, input logic [11:0] p2c1,
                                           input logic [11:0] p3c0, input logic [11:0] p3c1);
    return {p3c1, p3c0, p2c1, p2c0, p1c1, p1c0, p0c1, p0c0};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge VID_CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic vs, input logic hs, input logic de);
    S_VS = vs;
    S_HS = hs;
    S_DE = de;
  endtask

  task automatic setCfg(input logic [1:0] mode, input logic [1:0] depth);
    TRANSFER_MODE = mode;
    RAW_BIT_NUM   = depth;
  endtask

  task automatic vsPulse();
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);
  endtask

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] origExp, yuvExp, rggbL0, rggbL1, rggb12L0, rggb10L0;
    origExp  = mk(12'h0F1, 12'h0F3, 12'h0E1, 12'h0E3, 12'h0C1, 12'h0C3, 12'h081, 12'h083);
    yuvExp   = mk(12'h0F1, 12'h0F3, 12'h0E1, 12'h0E7, 12'h0C1, 12'h0C3, 12'h081, 12'h087);
    rggbL0   = mk(12'h0F1, 12'h000, 12'h0E3, 12'h000, 12'h0C1, 12'h000, 12'h083, 12'h000);
    rggbL1   = mk(12'h0F3, 12'h000, 12'h0E7, 12'h000, 12'h0C3, 12'h000, 12'h087, 12'h000);
    rggb12L0 = mk(12'hF10, 12'h000, 12'hE30, 12'h000, 12'hC10, 12'h000, 12'h830, 12'h000);
    rggb10L0 = mk(12'h3C4, 12'h000, 12'h38C, 12'h000, 12'h304, 12'h000, 12'h20C, 12'h000);

    S_R_Y = 32'h81C1E1F1;
    S_G_U = 32'h83C3E3F3;
    S_B_V = 32'h87C7E7F7;
    VID_RSTN = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    setCfg(2'd0, 2'd0);
    $display("[TB] reset phase");
    step(3);
    checkOutput("reset_vs", DATA_W'(M_VS), '0);
    checkOutput("reset_hs", DATA_W'(M_HS), '0);
    checkOutput("reset_de", DATA_W'(M_DE), '0);
    checkOutput("reset_data", M_VID_DATA, '0);

    VID_RSTN = 1'b1;
    step(2);
    checkOutput("idle_data", M_VID_DATA, '0);

    // Sync delay line: two-cycle latency
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(1);
    checkOutput("vs_lat1", DATA_W'(M_VS), '0);
    step(1);
    checkOutput("vs_lat2", DATA_W'(M_VS), DATA_W'(1'b1));
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(2);
    checkOutput("hs_lat2", DATA_W'(M_HS), DATA_W'(1'b1));
    checkOutput("vs_fall", DATA_W'(M_VS), '0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(2);

    $display("[TB] ORIGINAL 8-bit");
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(1);
    checkOutput("de_lat1", DATA_W'(M_DE), '0);
    step(1);
    checkOutput("de_lat2", DATA_W'(M_DE), DATA_W'(1'b1));
    checkOutput("orig8", M_VID_DATA, origExp);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(2);
    checkOutput("de_low_data", M_VID_DATA, '0);

    $display("[TB] mid-frame config changes");
    setCfg(2'd1, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(2);
    checkOutput("midframe_mode1", M_VID_DATA, origExp);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(2);
    setCfg(2'd2, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(2);
    checkOutput("midframe_mode2", M_VID_DATA, origExp);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(2);

    $display("[TB] RGGB 8-bit");
    vsPulse();
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(2);
    checkOutput("rggb8_line0", M_VID_DATA, rggbL0);
    step(1);
    checkOutput("rggb8_line0_beat1", M_VID_DATA, rggbL0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(2);
    checkOutput("rggb8_line1", M_VID_DATA, rggbL1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    step(2);
    checkOutput("vs_during_de", M_VID_DATA, rggbL0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(2);

    $display("[TB] RGGB 12-bit / 10-bit");
    setCfg(2'd2, 2'd2);
    vsPulse();
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(2);
    checkOutput("rggb12_line0", M_VID_DATA, rggb12L0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(2);
    setCfg(2'd2, 2'd1);
    vsPulse();
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(2);
    checkOutput("rggb10_line0", M_VID_DATA, rggb10L0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(2);

    $display("[TB] YUV422 8-bit");
    setCfg(2'd1, 2'd0);
    vsPulse();
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(2);
    checkOutput("yuv422", M_VID_DATA, yuvExp);

    $display("[TB] reset mid-frame");
    VID_RSTN = 1'b0;
    #1;
    checkOutput("midreset_de", DATA_W'(M_DE), '0);
    checkOutput("midreset_data", M_VID_DATA, '0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(2);
    VID_RSTN = 1'b1;
    setCfg(2'd2, 2'd0);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(2);
    checkOutput("noframe_cfg_line0", M_VID_DATA, rggbL0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(2);
    checkOutput("noframe_line1", M_VID_DATA, rggbL1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(2);
    vsPulse();
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(2);
    checkOutput("restart_line0", M_VID_DATA, rggbL0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
